rgbw_pwm_out: RTL
=================

Name: rgbw_pwm_out

Overview:
- Four-channel PWM output stage sitting directly downstream of colorGen.
- Consumes the red/green/blue/white duty bytes and drives the four lamp pins.
- Double-buffers the duties so that a new colour only takes effect at a PWM period boundary. This prevents glitches mid-period.
- Counts only on the clk_half enable produced by clockDividerPwm.

Parameters:
- PERIOD_TOP, 254: last counter value; the period is PERIOD_TOP+1 enabled ticks. Legal range is 1..254.
- PHASE_OFS, 64: per-channel phase offset in ticks. Used only when PWM_PHASE_STAGGER_EN is defined.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- clk_half  in  1  count enable, one clk cycle wide, from clockDividerPwm
- duty_vld  in  1  strobe: capture duty0..duty3 this cycle
- duty0  in  8  red duty
- duty1  in  8  green duty
- duty2  in  8  blue duty
- duty3  in  8  white duty
- duty_ack  out  1  one-cycle pulse: duties captured into the shadow registers
- period_start  out  1  one-cycle pulse: counter wrapped to 0
- d0  out  1  red PWM pin
- d1  out  1  green PWM pin
- d2  out  1  blue PWM pin
- d3  out  1  white PWM pin

Behaviour:
- Reset applies on any rising clk edge with reset==0. It clears:
  - cnt (8 bit)
  - shadow[0..3] and active[0..3]
  - pending
  - d0..d3, duty_ack, period_start
- Counter:
  - Advances only on cycles with clk_half==1.
  - If cnt==PERIOD_TOP it wraps to 0; otherwise cnt+1.
  - With clk_half==0, cnt holds its value.
- Shadow load:
  - On duty_vld==1, shadow[k] <= duty k and pending <= 1.
  - duty_ack goes high on the next cycle for exactly one cycle.
  - duty_vld is accepted every cycle with no busy state. The last write before a wrap wins.
- Wrap event (clk_half==1 and cnt==PERIOD_TOP):
  - period_start pulses high on the next cycle.
  - If pending==1: active[k] <= shadow[k] and pending <= 0.
  - Simultaneous duty_vld and wrap: the new duty inputs go directly to active and shadow, and pending ends at 0. The new inputs are not lost and not delayed a period.
- Compare:
  - Combinational: on_k = (phase_cnt_k < active[k]).
  - Registered: d_k <= on_k every clk, independent of clk_half. Latency from a cnt change to a pin change is one clk.
  - Without stagger, phase_cnt_k = cnt.
- Boundary values:
  - duty 0 gives a pin constantly low.
  - duty >= PERIOD_TOP+1 gives a pin constantly high. With default parameters duty 255 is 100 %.
  - duty N gives exactly N high ticks per period.
- Reset mid-period: all pins go low next cycle and the counter restarts at 0. Any pending update is discarded.
- clk_half held low: the pins freeze at their current levels. No update is applied, because no wrap occurs.

Optional Feature:
- Macro: PWM_PHASE_STAGGER_EN.
- Defined:
  - phase_cnt_k = cnt + k*PHASE_OFS, computed 9 bits wide.
  - If the result exceeds PERIOD_TOP, subtract PERIOD_TOP+1.
  - This spreads the four channel turn-on edges to reduce peak supply current. Duty ratios are unchanged.
- Undefined: all channels compare against cnt and turn on together at cnt==0.

Decomposition:
- Shared package rgbw_pkg:
  - constants DUTY_W=8 and NUM_CH=4
  - default PERIOD_TOP and PHASE_OFS
  - typedef for an 8-bit duty value
- One natural sub-module, pwm_channel, instantiated 4 times. It holds shadow/active registers, the optional phase offset and the compare flop.
- Counter and wrap/pending control stay in the top of rgbw_pwm_out.

Test Plan:
- Reset behaviour: reset low for 3 clk with clk_half toggling -> d0..d3=0, period_start=0, duty_ack=0. After release, the first period_start comes 255 enabled ticks later.
- Basic duty: load duty0..3=0/1/128/255, then run 2 full periods with clk_half every 2nd clk. In the second period:
  - d0 high 0 ticks
  - d1 high 1 tick
  - d2 high 128 ticks
  - d3 high for all 255 ticks
- Double buffering: mid-period (cnt=100) load duty0=10 over an active 200. d0 keeps 200 ticks high for the rest of that period; the next period shows 10 ticks. duty_ack pulses 1 clk after duty_vld.
- Simultaneous event: assert duty_vld with duty1=50 on the same cycle as the wrap (cnt=254, clk_half=1). The very next period shows d1 high for exactly 50 ticks and pending reads 0.
- Reset mid-operation and enable stall:
  - Hold clk_half=0 for 20 clk at cnt=30 -> pins and cnt unchanged.
  - Then pulse reset at cnt=77 -> pins low next clk, cnt=0, and the loaded-but-pending update is lost.
- Stagger, with PWM_PHASE_STAGGER_EN defined: all duties 32. The rising edges of d0..d3 occur at cnt=0, 191, 127, 63 respectively, with 32 high ticks each.

Source files
------------

// File: rtl/rgbw_pkg.sv
// Shared constants and types for the RGBW PWM output stage.
// The phase helper is only exercised when PWM_PHASE_STAGGER_EN is defined.
package rgbw_pkg;
  localparam int DUTY_W         = 8;
  localparam int NUM_CH         = 4;
  localparam int PERIOD_TOP_DEF = 254;
  localparam int PHASE_OFS_DEF  = 64;

  typedef logic [DUTY_W-1:0] duty_t;

  // Offset is pre-reduced below top+1, so one conditional subtract wraps it.
  function automatic duty_t phase_of(input duty_t cnt, input int ofs, input int top);
    logic [DUTY_W:0] sum;
    sum = {1'b0, cnt} + (DUTY_W+1)'(ofs);
    if (sum > (DUTY_W+1)'(top))
      sum = sum - (DUTY_W+1)'(top + 1);
    return sum[DUTY_W-1:0];
  endfunction
endpackage

// File: rtl/rgbw_pwm_out_channel.sv
// One PWM lane: shadow/active duty pair, optional phase offset, registered compare.
// Phase stagger is enabled by defining PWM_PHASE_STAGGER_EN.
module pwm_channel
  import rgbw_pkg::*;
#(
  parameter int CH         = 0,
  parameter int PERIOD_TOP = PERIOD_TOP_DEF,
  parameter int PHASE_OFS  = PHASE_OFS_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_duty_vld,
  input  duty_t i_duty,
  input  logic  i_apply,
  input  duty_t i_cnt,
  output logic  o_pin
);
`ifdef PWM_PHASE_STAGGER_EN
  localparam bit STAGGER = 1'b1;
`else
  localparam bit STAGGER = 1'b0;
`endif
  localparam int CH_OFS = STAGGER ? (CH * PHASE_OFS) % (PERIOD_TOP + 1) : 0;

  duty_t r_shadow;
  duty_t r_active;
  logic  r_pin;
  duty_t w_phase;
  logic  w_on;

  assign w_phase = phase_of(i_cnt, CH_OFS, PERIOD_TOP);
  assign w_on    = (w_phase < r_active);
  assign o_pin   = r_pin;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pin    <= 1'b0;
    end else begin
      if (i_duty_vld)
        r_shadow <= i_duty;
      // A strobe coinciding with the wrap bypasses the shadow straight into active.
      if (i_apply)
        r_active <= i_duty_vld ? i_duty : r_shadow;
      r_pin <= w_on;
    end
  end
endmodule

// File: rtl/rgbw_pwm_out.sv
// Four-channel double-buffered PWM stage: shared period counter plus wrap/pending control.
// Define PWM_PHASE_STAGGER_EN to offset each channel's turn-on by k*PHASE_OFS ticks.
module rgbw_pwm_out
  import rgbw_pkg::*;
#(
  parameter int PERIOD_TOP = PERIOD_TOP_DEF,
  parameter int PHASE_OFS  = PHASE_OFS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_half,
  input  logic       duty_vld,
  input  logic [7:0] duty0,
  input  logic [7:0] duty1,
  input  logic [7:0] duty2,
  input  logic [7:0] duty3,
  output logic       duty_ack,
  output logic       period_start,
  output logic       d0,
  output logic       d1,
  output logic       d2,
  output logic       d3
);
  localparam duty_t TOP = duty_t'(PERIOD_TOP);

  duty_t             r_cnt;
  logic              r_pending;
  logic              r_ack;
  logic              r_pstart;
  logic              w_wrap;
  logic              w_apply;
  duty_t             w_duty [NUM_CH];
  logic [NUM_CH-1:0] w_pin;

  assign w_wrap    = clk_half && (r_cnt == TOP);
  assign w_apply   = w_wrap && (r_pending || duty_vld);
  assign w_duty[0] = duty0;
  assign w_duty[1] = duty1;
  assign w_duty[2] = duty2;
  assign w_duty[3] = duty3;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
      r_pstart  <= 1'b0;
    end else begin
      if (clk_half)
        r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap)
        r_pending <= 1'b0;
      else if (duty_vld)
        r_pending <= 1'b1;
      r_ack    <= duty_vld;
      r_pstart <= w_wrap;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pwm_channel #(
      .CH         (k),
      .PERIOD_TOP (PERIOD_TOP),
      .PHASE_OFS  (PHASE_OFS)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .i_duty_vld (duty_vld),
      .i_duty     (w_duty[k]),
      .i_apply    (w_apply),
      .i_cnt      (r_cnt),
      .o_pin      (w_pin[k])
    );
  end

  assign duty_ack     = r_ack;
  assign period_start = r_pstart;
  assign d0           = w_pin[0];
  assign d1           = w_pin[1];
  assign d2           = w_pin[2];
  assign d3           = w_pin[3];
endmodule
